// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and helpers for the BCD up/down counter.
//   SEG7        : seven-segment patterns for BCD digits 0..9 (bit 7 = dp, always 0)
//   SEG_BLANK   : all segments off
//   seg7_decode : BCD digit -> segment pattern; non-BCD codes decode to blank
package bcd_pkg;

  localparam logic [7:0] SEG7 [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  function automatic logic [7:0] seg7_decode(input logic [3:0] d);
    logic [7:0] r;
    r = SEG_BLANK;
    if (d <= BCD_MAX) r = SEG7[d];
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one 4-bit BCD digit register with up/down step and parallel load.
//   clock, reset    : board clock, synchronous active-high reset
//   step            : advance this digit one position this cycle
//   direction       : 1 = up (9 -> 0 rolls over), 0 = down (0 -> 9 rolls under)
//   load, load_digit: parallel load; values above 9 clamp to 9
//   digit           : registered digit value
//   is_max, is_min  : digit is 9 / digit is 0
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  input  logic       direction,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       is_max,
  output logic       is_min
);

  logic [3:0] r_digit;
  logic [3:0] w_load_clamped;

  assign w_load_clamped = (load_digit > BCD_MAX) ? BCD_MAX : load_digit;

  always_ff @(posedge clock) begin
    if (reset)
      r_digit <= 4'd0;
    else if (load)
      r_digit <= w_load_clamped;
    else if (step) begin
      if (direction)
        r_digit <= (r_digit >= BCD_MAX) ? 4'd0 : r_digit + 4'd1;
      else
        r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
    end
  end

  assign digit  = r_digit;
  assign is_max = (r_digit == BCD_MAX);
  assign is_min = (r_digit == 4'd0);

endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: NDIGITS-digit BCD up/down counter with seven-segment decode.
//   clock, reset : board clock, synchronous active-high reset
//   en           : count enable (one step per cycle)
//   direction    : 1 = up, 0 = down
//   load         : parallel load of load_value (digits clamped to 9), beats en
//   sat_mode     : 0 = wrap at limits, 1 = hold at limits
//   count_bcd    : registered BCD count, digit i at [4i+3:4i]
//   seg          : per-digit segment patterns, digit i at [8i+7:8i]
//   wrap         : one-cycle pulse in the cycle after a wrap
//   at_limit     : count is all-9s (up) or all-0s (down)
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int NDIGITS  = 2,
  parameter int BLANK_LZ = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 direction,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] load_value,
  input  logic                 sat_mode,
  output logic [4*NDIGITS-1:0] count_bcd,
  output logic [8*NDIGITS-1:0] seg,
  output logic                 wrap,
  output logic                 at_limit
);

  logic [NDIGITS-1:0][3:0] w_digit;
  logic [NDIGITS-1:0]      w_is_max;
  logic [NDIGITS-1:0]      w_is_min;
  logic [NDIGITS-1:0]      w_step;
  logic [NDIGITS-1:0]      w_blank;
  logic                    w_limit;
  logic                    w_count_en;
  logic                    w_wrap_evt;
  logic                    r_wrap;

  assign w_limit    = direction ? (&w_is_max) : (&w_is_min);
  // Saturation simply suppresses every step; wrapping needs no special case
  // because the ripple cascade naturally rolls all-9s to all-0s and back.
  assign w_count_en = en & ~(sat_mode & w_limit);
  assign w_wrap_evt = en & w_limit & ~sat_mode & ~load;

  // Digit i steps when every lower digit sits at its rollover value.
  always_comb begin
    logic w_carry;
    w_carry = 1'b1;
    w_step  = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      w_step[i] = w_count_en & w_carry;
      w_carry   = w_carry & (direction ? w_is_max[i] : w_is_min[i]);
    end
  end

  // Leading-zero blanking: scan from the top digit down; digit 0 is never blanked.
  always_comb begin
    logic w_zero;
    w_zero  = 1'b1;
    w_blank = '0;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      w_zero     = w_zero & w_is_min[i];
      w_blank[i] = (BLANK_LZ != 0) && w_zero;
    end
  end

  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_dig
    bcd_digit u_digit (
      .clock      (clock),
      .reset      (reset),
      .step       (w_step[gi]),
      .direction  (direction),
      .load       (load),
      .load_digit (load_value[4*gi +: 4]),
      .digit      (w_digit[gi]),
      .is_max     (w_is_max[gi]),
      .is_min     (w_is_min[gi])
    );
    assign count_bcd[4*gi +: 4] = w_digit[gi];
    assign seg[8*gi +: 8]       = w_blank[gi] ? SEG_BLANK : seg7_decode(w_digit[gi]);
  end

  always_ff @(posedge clock) begin
    if (reset) r_wrap <= 1'b0;
    else       r_wrap <= w_wrap_evt;
  end

  assign wrap     = r_wrap;
  assign at_limit = w_limit;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  localparam int ND = 2;

  logic          clock = 1'b0;
  logic          reset, en, direction, load, sat_mode;
  logic [4*ND-1:0] load_value;
  logic [4*ND-1:0] count_bcd, count_b;
  logic [8*ND-1:0] seg, seg_b;
  logic          wrap, wrap_b, at_limit, at_limit_b;

  int vectors    = 0;
  int miscompares = 0;
  bit started    = 0;

  // Behavioural model: count kept as a plain integer 0..99.
  int m_cnt  = 0;
  bit m_wrap = 0;

  logic [7:0] seg_tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  always #5 clock = ~clock;

  bcd_updown_counter #(.NDIGITS(ND), .BLANK_LZ(0)) dut (
    .clock(clock), .reset(reset), .en(en), .direction(direction), .load(load),
    .load_value(load_value), .sat_mode(sat_mode), .count_bcd(count_bcd),
    .seg(seg), .wrap(wrap), .at_limit(at_limit));

  bcd_updown_counter #(.NDIGITS(ND), .BLANK_LZ(1)) dut_b (
    .clock(clock), .reset(reset), .en(en), .direction(direction), .load(load),
    .load_value(load_value), .sat_mode(sat_mode), .count_bcd(count_b),
    .seg(seg_b), .wrap(wrap_b), .at_limit(at_limit_b));

  function automatic int clamp_val(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]); lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] hi, lo;
    hi = 4'(n / 10); lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_cnt = 0; m_wrap = 0;
    end else if (load) begin
      m_cnt = clamp_val(load_value); m_wrap = 0;
    end else if (en) begin
      m_wrap = 0;
      if (direction) begin
        if (m_cnt == 99) begin
          if (!sat_mode) begin m_cnt = 0; m_wrap = 1; end
        end else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin
          if (!sat_mode) begin m_cnt = 99; m_wrap = 1; end
        end else m_cnt = m_cnt - 1;
      end
    end else m_wrap = 0;
  end

  always @(negedge clock) begin
    if (started) begin
      logic [7:0] hi_b;
      hi_b = (m_cnt / 10 == 0) ? 8'h00 : seg_tab[m_cnt / 10];
      check("count",    32'(count_bcd), 32'(to_bcd(m_cnt)));
      check("wrap",     32'(wrap),      32'(m_wrap));
      check("at_limit", 32'(at_limit),  32'(direction ? (m_cnt == 99) : (m_cnt == 0)));
      check("seg",      32'(seg),       32'({seg_tab[m_cnt / 10], seg_tab[m_cnt % 10]}));
      check("count_b",  32'(count_b),   32'(to_bcd(m_cnt)));
      check("wrap_b",   32'(wrap_b),    32'(m_wrap));
      check("seg_b",    32'(seg_b),     32'({hi_b, seg_tab[m_cnt % 10]}));
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1; load_value = v; tick(1); load = 0;
  endtask

  initial begin
    reset = 1; en = 0; direction = 0; load = 0; load_value = '0; sat_mode = 0;
    tick(2);
    started = 1;
    @(negedge clock);
    check("rst_count", 32'(count_bcd), 32'h00);
    check("rst_wrap",  32'(wrap), 32'h0);
    check("rst_seg",   32'(seg), 32'h3F3F);
    check("rst_seg_b", 32'(seg_b), 32'h003F);
    check("rst_at_limit_down", 32'(at_limit), 32'h1);

    // Count up through the full range and wrap.
    reset = 0; en = 1; direction = 1; sat_mode = 0;
    tick(99);
    @(negedge clock);
    check("up_99", 32'(count_bcd), 32'h99);
    check("up_99_seg", 32'(seg), 32'h6F6F);
    check("up_99_limit", 32'(at_limit), 32'h1);
    tick(1);
    @(negedge clock);
    check("up_wrap_cnt", 32'(count_bcd), 32'h00);
    check("up_wrap_pulse", 32'(wrap), 32'h1);
    check("up_wrap_seg0", 32'(seg[7:0]), 32'h3F);
    tick(1);
    @(negedge clock);
    check("up_after_wrap", 32'(wrap), 32'h0);

    // Down from 00 wraps to 99, then 98.
    en = 0; do_load(8'h00);
    en = 1; direction = 0;
    tick(1);
    @(negedge clock);
    check("dn_wrap_cnt", 32'(count_bcd), 32'h99);
    check("dn_wrap_pulse", 32'(wrap), 32'h1);
    tick(1);
    @(negedge clock);
    check("dn_98", 32'(count_bcd), 32'h98);
    check("dn_98_seg1", 32'(seg[15:8]), 32'h6F);

    // Saturate at 99 going up, and at 00 going down.
    en = 0; do_load(8'h99);
    en = 1; direction = 1; sat_mode = 1;
    tick(5);
    @(negedge clock);
    check("sat_99", 32'(count_bcd), 32'h99);
    check("sat_99_limit", 32'(at_limit), 32'h1);
    en = 0; do_load(8'h01);
    en = 1; direction = 0;
    tick(4);
    @(negedge clock);
    check("sat_00", 32'(count_bcd), 32'h00);
    check("sat_00_wrap", 32'(wrap), 32'h0);

    // Load clamps and beats en; next up step carries.
    sat_mode = 0; direction = 1; en = 1;
    do_load(8'h4C);
    @(negedge clock);
    check("load_clamp", 32'(count_bcd), 32'h49);
    tick(1);
    @(negedge clock);
    check("load_then_up", 32'(count_bcd), 32'h50);
    do_load(8'hF5);
    @(negedge clock);
    check("load_clamp_hi", 32'(count_bcd), 32'h95);

    // Back-to-back wraps: up at 99 then down at 00.
    do_load(8'h99);
    en = 1; direction = 1; tick(1);
    direction = 0; tick(1);
    @(negedge clock);
    check("b2b_cnt", 32'(count_bcd), 32'h99);
    check("b2b_wrap", 32'(wrap), 32'h1);

    // Wrap followed by a load clears the pulse.
    direction = 1; tick(1);
    do_load(8'h12);
    @(negedge clock);
    check("load_clr_wrap", 32'(wrap), 32'h0);

    // Reset beats load and en.
    en = 0; do_load(8'h37);
    reset = 1; load = 1; load_value = 8'h55; en = 1; tick(1);
    reset = 0; load = 0; en = 0;
    @(negedge clock);
    check("rst_mid_cnt", 32'(count_bcd), 32'h00);
    check("rst_mid_seg_b", 32'(seg_b), 32'h003F);

    // Hold with direction toggling.
    do_load(8'h63);
    for (int k = 0; k < 6; k++) begin
      direction = ~direction; sat_mode = k[0]; tick(1);
    end
    @(negedge clock);
    check("hold_cnt", 32'(count_bcd), 32'h63);
    check("hold_wrap", 32'(wrap), 32'h0);

    // Mixed up/down walk checked by the model.
    en = 1;
    for (int k = 0; k < 30; k++) begin
      direction = (k % 7) < 4; sat_mode = (k % 5) == 0; tick(1);
    end
    en = 0; tick(1);

    @(negedge clock);
    started = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
